// File: rtl/ej32_rom_ldr.sv
// Cold-start loader: copies LEN bytes from the boot ROM into SRAM over the 8-bit bus,
// owning the bus (rom_en) for the duration and raising a sticky done when finished.
module ej32_rom_ldr #(
  parameter int               ASZ = 17,
  parameter logic [ASZ-1:0]   SRC = '0,
  parameter logic [ASZ-1:0]   DST = '0,
  parameter logic [ASZ:0]     LEN = 'h1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           hold,
  output logic [ASZ-1:0] rom_a,
  input  logic [7:0]     rom_d,
  output logic           rom_en,
  output logic [ASZ-1:0] mem_a,
  output logic [7:0]     mem_d,
  output logic           mem_we,
  output logic           busy,
  output logic           done,
  output logic [7:0]     csum,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {IDLE, PRIME, COPY, FIN} state_t;

  localparam logic [ASZ:0] ONE  = {{ASZ{1'b0}}, 1'b1};
  localparam logic [ASZ:0] LAST = LEN - ONE;

  state_t         state, state_n;
  logic [ASZ:0]   count;
  logic [ASZ-1:0] mem_a_q;
  logic [7:0]     mem_d_q;
  logic [7:0]     csum_q;
  logic           done_q;
  logic           wr;
  logic           last;

  assign wr   = (state == COPY) && !hold;
  assign last = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = (LEN != '0) ? PRIME : FIN;
      PRIME: if (!hold) state_n = COPY;
      COPY:  if (wr && last) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers: counter, checksum, sticky done, and the last written address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      mem_a_q <= DST;
      mem_d_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        count  <= '0;
        csum_q <= '0;
        done_q <= 1'b0;
      end
      if (wr) begin
        count   <= count + ONE;
        csum_q  <= csum_q + rom_d;
        mem_a_q <= DST + count[ASZ-1:0];
        mem_d_q <= rom_d;
        if (last) done_q <= 1'b1;
      end
      // Covers the zero-length path, which reaches FIN without ever writing.
      if (state == FIN) done_q <= 1'b1;
    end
  end

  // While writing, the ROM is already fetching the next byte; while held, the pending
  // byte's address is re-presented so rom_d is still that byte once hold drops.
  always_comb begin
    busy      = (state == PRIME) || (state == COPY);
    rom_en    = busy;
    mem_we    = wr;
    rom_a     = SRC + count[ASZ-1:0] + ASZ'(wr);
    mem_a     = wr ? (DST + count[ASZ-1:0]) : mem_a_q;
    mem_d     = wr ? rom_d : mem_d_q;
    done      = done_q;
    csum      = csum_q;
    state_dbg = state;
  end

endmodule
